ram_bus_pipe: RTL and testbench
===============================

Name: ram_bus_pipe

Overview:
Parametrised successor to the single-cycle byte-lane RAM bus slave. It serves one read port and one write port against a word-organised RAM with per-byte write enables. It adds a configurable read latency pipeline with an explicit valid strobe, write-first forwarding for same-word collisions, and address-window decode with error reporting. It sits behind the core's instruction/data bus as the on-chip memory slave.

Parameters:
DATA_W, 32, data width in bits; multiple of 8; NB = DATA_W/8 byte lanes.
DEPTH, 1024, words; power of two; AW = log2(DEPTH).
ADDR_W, 32, byte-address width.
BASE_ADDR, 0, byte base of window; aligned to DEPTH*NB.
RD_LAT, 1, read latency in cycles; legal 1..4.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rd_req  in  1  read request
rd_addr  in  ADDR_W  read byte address
rd_gnt  out  1  read accepted
rd_valid  out  1  rd_data/rd_err valid
rd_data  out  DATA_W  read data
rd_err  out  1  read was out of window
wr_req  in  1  write request
wr_addr  in  ADDR_W  write byte address
wr_be  in  NB  byte enables, bit i -> data[8i+7:8i]
wr_data  in  DATA_W  write data
wr_gnt  out  1  write accepted
wr_err  out  1  previous-cycle write was out of window

Behaviour:
- Interface is decided: one clock clk; reset rst is synchronous, active-high.
- rd_gnt = rd_req, wr_gnt = wr_req; combinational, never stalls, including during rst.
- Word index is addr[log2(NB)+AW-1 : log2(NB)]. Low log2(NB) bits are ignored, so misaligned addresses are truncated and raise no error.
- In-window means BASE_ADDR <= addr < BASE_ADDR + DEPTH*NB, compared over the full ADDR_W.
- Write: on clk edge with wr_req=1, in-window and rst=0, lanes with wr_be[i]=1 are updated. Other lanes are unchanged. wr_be=0 is a legal no-op.
- Out-of-window write: the RAM is unchanged. wr_err=1 for exactly the next cycle.
- Read: an accepted read samples the array on the acceptance edge (stage 1). Stages 2..RD_LAT are plain registers.
  - rd_valid=1 exactly RD_LAT cycles after the request cycle.
  - Back-to-back reads give back-to-back valids with full throughput, in order.
- Out-of-window read: rd_data=0, rd_err=1, with the same latency and valid timing.
- Collision, same cycle and same word: the read returns wr_data for enabled lanes and old contents for the rest (write-first). Forwarding is suppressed if either access is out of window.
- Reads in flight are snapshots; a later write does not alter data already in stages 1..RD_LAT.
- Reset values: rd_valid=0, rd_err=0, wr_err=0, rd_data=0. All pipeline valid bits are cleared.
- RAM contents are not reset and are retained across rst.
- Reset mid-operation: in-flight reads are dropped and produce no rd_valid. A write coinciding with rst=1 is not performed.
- rd_data holds its last value when rd_valid=0; consumers qualify it with rd_valid.
- Elaboration error if RD_LAT is outside 1..4, DATA_W%8!=0, or DEPTH is not a power of two.

Test Plan:
- Defaults; write addr 0x10, be=4'hF, data 0xDEADBEEF; read 0x10 next cycle -> one cycle later rd_valid=1, rd_data=0xDEADBEEF, rd_err=0.
- Partial write to 0x10, be=4'b0101, data 0x11223344 -> read returns 0xDE22BE44; read of 0x13 also returns 0xDE22BE44.
- Same-cycle write 0x20 (old 0xAAAAAAAA, be=4'b1100, data 0x55667788) and read 0x20 -> rd_data=0x5566AAAA; next read -> 0x5566AAAA.
- RD_LAT=3; reads to 0x0, 0x4, 0x8 on consecutive cycles (preloaded 1,2,3) -> rd_valid high for 3 consecutive cycles starting at cycle+3, data 1,2,3. A write to 0x4 one cycle after its read does not change the returned value 2.
- Out of window: write 0x1000 (DEPTH=1024) -> wr_err pulses one cycle and word 0 is unchanged. Read 0x1000 -> rd_valid=1, rd_err=1, rd_data=0.
- RD_LAT=2; issue 2 reads, assert rst for 1 cycle the cycle after the second read -> no rd_valid appears. RAM content is readable unchanged after reset.

Source files
------------

// File: rtl/ram_bus_pipe.sv
// On-chip memory slave: one read port and one write port against a word RAM
// with per-byte write enables. It has a configurable read latency, write-first
// forwarding on same-word collisions, and address-window error reporting.
module ram_bus_pipe #(
  parameter int unsigned          DATA_W    = 32,
  parameter int unsigned          DEPTH     = 1024,
  parameter int unsigned          ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]    BASE_ADDR = '0,
  parameter int unsigned          RD_LAT    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rd_req,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic                 rd_gnt,
  output logic                 rd_valid,
  output logic [DATA_W-1:0]    rd_data,
  output logic                 rd_err,
  input  logic                 wr_req,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [DATA_W/8-1:0]  wr_be,
  input  logic [DATA_W-1:0]    wr_data,
  output logic                 wr_gnt,
  output logic                 wr_err
);
  localparam int unsigned NB = DATA_W / 8;
  localparam int unsigned LB = $clog2(NB);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [ADDR_W:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0] WIN_SZ = (ADDR_W+1)'(DEPTH * NB);

  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
    $error("ram_bus_pipe: RD_LAT must be in 1..4");
  end
  if (DATA_W == 0 || (DATA_W % 8) != 0) begin : g_bad_width
    $error("ram_bus_pipe: DATA_W must be a non-zero multiple of 8");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("ram_bus_pipe: DEPTH must be a power of two (>= 2)");
  end
  if (LB + AW > ADDR_W) begin : g_bad_addr
    $error("ram_bus_pipe: ADDR_W too narrow for DEPTH and DATA_W");
  end

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [AW-1:0]     rd_idx;
  logic [AW-1:0]     wr_idx;
  logic [ADDR_W:0]   rd_off;
  logic [ADDR_W:0]   wr_off;
  logic              rd_in_win;
  logic              wr_in_win;
  logic              wr_en;
  logic              fwd;
  logic [DATA_W-1:0] rd_word;

  logic [RD_LAT-1:0] valid_d, valid_q;
  logic [RD_LAT-1:0] err_d, err_q;
  logic [DATA_W-1:0] data_d [RD_LAT];
  logic [DATA_W-1:0] data_q [RD_LAT];
  logic              wr_err_d, wr_err_q;

  // Address decode, window check and write-first merge of the word being read.
  // Window test is a subtract-and-compare one bit wider than the address, so a
  // below-base address wraps to a huge offset and fails the size compare.
  always_comb begin
    rd_idx    = rd_addr[LB +: AW];
    wr_idx    = wr_addr[LB +: AW];
    rd_off    = {1'b0, rd_addr} - WIN_LO;
    wr_off    = {1'b0, wr_addr} - WIN_LO;
    rd_in_win = rd_off < WIN_SZ;
    wr_in_win = wr_off < WIN_SZ;
    wr_en     = wr_req && wr_in_win && !rst;
    fwd       = rd_req && rd_in_win && wr_en && (rd_idx == wr_idx);
    rd_word   = mem_q[rd_idx];
    for (int unsigned b = 0; b < NB; b++) begin
      if (fwd && wr_be[b]) rd_word[8*b +: 8] = wr_data[8*b +: 8];
    end
    if (!rd_in_win) rd_word = '0;
  end

  // RAM array: byte-lane writes, never reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (wr_be[b]) mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Read pipeline next state; data/err stages load only behind a valid entry
  // so the last stage holds the most recent result while idle.
  always_comb begin
    valid_d   = '0;
    err_d     = err_q;
    valid_d[0] = rd_req;
    data_d[0]  = rd_req ? rd_word : data_q[0];
    err_d[0]   = rd_req ? !rd_in_win : err_q[0];
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      valid_d[i] = valid_q[i-1];
      data_d[i]  = valid_q[i-1] ? data_q[i-1] : data_q[i];
      err_d[i]   = valid_q[i-1] ? err_q[i-1]  : err_q[i];
    end
    wr_err_d = wr_req && !wr_in_win;
  end

  // Pipeline and error registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= '0;
      err_q    <= '0;
      wr_err_q <= 1'b0;
      for (int unsigned i = 0; i < RD_LAT; i++) data_q[i] <= '0;
    end else begin
      valid_q  <= valid_d;
      err_q    <= err_d;
      wr_err_q <= wr_err_d;
      for (int unsigned i = 0; i < RD_LAT; i++) data_q[i] <= data_d[i];
    end
  end

  assign rd_gnt   = rd_req;
  assign wr_gnt   = wr_req;
  // Masked by rst so an in-flight read reaching the output during reset is dropped.
  assign rd_valid = valid_q[RD_LAT-1] && !rst;
  assign rd_err   = err_q[RD_LAT-1] && !rst;
  assign rd_data  = data_q[RD_LAT-1];
  assign wr_err   = wr_err_q;

endmodule

// File: tb/tb_ram_bus_pipe.sv
// Directed bench: three instances (RD_LAT = 1, 3, 2) share one stimulus stream,
// so their RAM contents stay identical and each is checked at its own latency.
module tb_ram_bus_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;

  logic        rd_gnt1, rd_valid1, rd_err1, wr_gnt1, wr_err1;
  logic [31:0] rd_data1;
  logic        rd_gnt3, rd_valid3, rd_err3, wr_gnt3, wr_err3;
  logic [31:0] rd_data3;
  logic        rd_gnt2, rd_valid2, rd_err2, wr_gnt2, wr_err2;
  logic [31:0] rd_data2;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  ram_bus_pipe #(.RD_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt1),
    .rd_valid(rd_valid1), .rd_data(rd_data1), .rd_err(rd_err1), .wr_req(wr_req),
    .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data), .wr_gnt(wr_gnt1), .wr_err(wr_err1)
  );
  ram_bus_pipe #(.RD_LAT(3)) u_lat3 (
    .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt3),
    .rd_valid(rd_valid3), .rd_data(rd_data3), .rd_err(rd_err3), .wr_req(wr_req),
    .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data), .wr_gnt(wr_gnt3), .wr_err(wr_err3)
  );
  ram_bus_pipe #(.RD_LAT(2)) u_lat2 (
    .clk(clk), .rst(rst), .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt2),
    .rd_valid(rd_valid2), .rd_data(rd_data2), .rd_err(rd_err2), .wr_req(wr_req),
    .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data), .wr_gnt(wr_gnt2), .wr_err(wr_err2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    rd_req = 1'b0;
    wr_req = 1'b0;
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  task automatic set_wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    wr_req = 1'b1; wr_addr = a; wr_be = be; wr_data = d;
  endtask

  task automatic set_rd(input logic [31:0] a);
    rd_req = 1'b1; rd_addr = a;
  endtask

  task automatic write_word(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    rd_req = 1'b0;
    set_wr(a, be, d);
    step();
    wr_req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rd_req = 1'b0; rd_addr = '0;
    wr_req = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
    step(); step();
    // Reset state, and grants stay combinational during reset.
    check("rst_rd_valid1", 32'(rd_valid1), 32'd0);
    check("rst_rd_valid3", 32'(rd_valid3), 32'd0);
    check("rst_rd_err1",   32'(rd_err1),   32'd0);
    check("rst_wr_err1",   32'(wr_err1),   32'd0);
    check("rst_rd_data1",  rd_data1,       32'd0);
    check("rst_rd_data3",  rd_data3,       32'd0);
    rd_req = 1'b1; wr_req = 1'b1; wr_addr = 32'h1000; #1;
    check("rst_rd_gnt", 32'(rd_gnt1), 32'd1);
    check("rst_wr_gnt", 32'(wr_gnt2), 32'd1);
    step();
    check("rst_no_valid", 32'(rd_valid1), 32'd0);
    check("rst_no_wr_err", 32'(wr_err1), 32'd0);
    rst = 1'b0;
    idle(4);

    // Full-word write then read.
    write_word(32'h10, 4'hF, 32'hDEADBEEF);
    set_rd(32'h10); step(); rd_req = 1'b0;
    check("t1_valid", 32'(rd_valid1), 32'd1);
    check("t1_data",  rd_data1, 32'hDEADBEEF);
    check("t1_err",   32'(rd_err1), 32'd0);
    check("t1_wr_err", 32'(wr_err1), 32'd0);
    step();
    check("t1_valid_drop", 32'(rd_valid1), 32'd0);
    check("t1_data_hold", rd_data1, 32'hDEADBEEF);
    idle(4);

    // Partial write; misaligned read address truncates to the same word.
    write_word(32'h10, 4'b0101, 32'h11223344);
    set_rd(32'h10); step();
    check("t2_data", rd_data1, 32'hDE22BE44);
    set_rd(32'h13); step();
    check("t2_misalign_data", rd_data1, 32'hDE22BE44);
    check("t2_misalign_err", 32'(rd_err1), 32'd0);
    idle(4);

    // Same-cycle collision: write-first forwarding on enabled lanes.
    write_word(32'h20, 4'hF, 32'hAAAAAAAA);
    set_wr(32'h20, 4'b1100, 32'h55667788);
    set_rd(32'h20); step(); wr_req = 1'b0;
    check("t3_fwd", rd_data1, 32'h5566AAAA);
    set_rd(32'h20); step();
    check("t3_after", rd_data1, 32'h5566AAAA);
    idle(4);

    // RD_LAT=3 back-to-back reads; later write does not disturb a snapshot.
    write_word(32'h0, 4'hF, 32'd1);
    write_word(32'h4, 4'hF, 32'd2);
    write_word(32'h8, 4'hF, 32'd3);
    set_rd(32'h0); step();
    set_rd(32'h4); step();
    check("t4_not_yet", 32'(rd_valid3), 32'd0);
    set_rd(32'h8); set_wr(32'h4, 4'hF, 32'hFFFFFFFF); step();
    rd_req = 1'b0; wr_req = 1'b0;
    check("t4_v0", 32'(rd_valid3), 32'd1);
    check("t4_d0", rd_data3, 32'd1);
    step();
    check("t4_v1", 32'(rd_valid3), 32'd1);
    check("t4_d1_snapshot", rd_data3, 32'd2);
    step();
    check("t4_v2", 32'(rd_valid3), 32'd1);
    check("t4_d2", rd_data3, 32'd3);
    step();
    check("t4_v_end", 32'(rd_valid3), 32'd0);
    idle(4);

    // Out-of-window write and read; last in-window word as boundary.
    write_word(32'h1000, 4'hF, 32'h12345678);
    check("t5_wr_err", 32'(wr_err1), 32'd1);
    step();
    check("t5_wr_err_pulse", 32'(wr_err1), 32'd0);
    set_rd(32'h0); step(); rd_req = 1'b0;
    check("t5_word0_kept", rd_data1, 32'd1);
    set_rd(32'h1000); step(); rd_req = 1'b0;
    check("t5_oow_valid", 32'(rd_valid1), 32'd1);
    check("t5_oow_err",   32'(rd_err1), 32'd1);
    check("t5_oow_data",  rd_data1, 32'd0);
    step(); step();
    check("t5_oow_err_lat3",  32'(rd_err3), 32'd1);
    check("t5_oow_data_lat3", rd_data3, 32'd0);
    write_word(32'hFFC, 4'hF, 32'hCAFEF00D);
    check("t5_edge_wr_err", 32'(wr_err1), 32'd0);
    set_rd(32'hFFC); step(); rd_req = 1'b0;
    check("t5_edge_data", rd_data1, 32'hCAFEF00D);
    check("t5_edge_err",  32'(rd_err1), 32'd0);
    idle(4);

    // RD_LAT=2: reset right after two reads drops both; RAM survives.
    set_rd(32'h10); step();
    set_rd(32'h20); step();
    rd_req = 1'b0; rst = 1'b1; #1;
    check("t6_rst_valid", 32'(rd_valid2), 32'd0);
    step();
    rst = 1'b0;
    check("t6_after_rst0", 32'(rd_valid2), 32'd0);
    step();
    check("t6_after_rst1", 32'(rd_valid2), 32'd0);
    step();
    check("t6_after_rst2", 32'(rd_valid2), 32'd0);
    set_rd(32'h10); step();
    set_rd(32'h20); step(); rd_req = 1'b0;
    check("t6_v0", 32'(rd_valid2), 32'd1);
    check("t6_d0", rd_data2, 32'hDE22BE44);
    step();
    check("t6_d1", rd_data2, 32'h5566AAAA);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
